// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: rotates active-low digit enables,
// decodes the returned hex digit into blanked, registered segment/dp lines.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            num,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_RST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic             DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [CNT_W-1:0]      div_cnt, div_next;
    logic [IDX_W-1:0]      idx, idx_next, above_idx, lowest_idx;
    logic                  act, act_next;
    logic                  boundary, found_above, found_any, show;
    logic [NUM_DIGITS-1:0] en_next;
    logic [6:0]            seg_next;
    logic                  dp_next, tick_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Find both the next used digit above idx and the lowest used digit, for circular wrap.
    always_comb begin
        found_above = 1'b0;
        found_any   = 1'b0;
        above_idx   = idx;
        lowest_idx  = idx;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_mask[i]) begin
                if (!found_any) begin
                    lowest_idx = IDX_W'(i);
                    found_any  = 1'b1;
                end
                if (!found_above && (i > int'(idx))) begin
                    above_idx   = IDX_W'(i);
                    found_above = 1'b1;
                end
            end
        end
    end

    // Outputs are computed from the post-edge slot position so that the first
    // cycle of a new slot is already blanked and never shows the old digit.
    always_comb begin
        boundary = (div_cnt == CNT_LAST);
        div_next = boundary ? '0 : div_cnt + 1'b1;
        idx_next = idx;
        act_next = act;
        if (boundary) begin
            act_next = found_any;
            if (found_any) begin
                idx_next = found_above ? above_idx : lowest_idx;
            end
        end
        tick_next = boundary && found_any && (idx_next <= idx);
        en_next   = (act_next && digit_mask[idx_next]) ? ~(NUM_DIGITS'(1) << idx_next) : '1;
        show      = (en_next != '1) && (int'(div_next) >= BLANK_CYC);
        seg_next  = SEG_OFF;
        dp_next   = DP_OFF;
        if (show) begin
            seg_next = (SEG_ACTIVE_LOW != 0) ? ~hex_to_seg(num) : hex_to_seg(num);
            dp_next  = dp_mask[idx_next] ^ DP_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            idx        <= IDX_RST;
            act        <= 1'b0;
            en         <= '1;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            idx        <= idx_next;
            act        <= act_next;
            en         <= en_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_tick <= tick_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: random digit values and masks checked
// against a slot-arithmetic reference model, plus directed mask/reset edge cases.
module tb_seg_scan_driver;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int BL = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    num;
    logic [ND-1:0] digit_mask = '0;
    logic [ND-1:0] dp_mask = '0;
    logic [ND-1:0] en;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_tick;

    logic [3:0] digit_val [ND];
    logic [3:0] prev_val  [ND];
    logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int step  = 0;

    seg_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BL), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .num(num), .digit_mask(digit_mask), .dp_mask(dp_mask),
        .en(en), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Upstream digit counter stand-in: returns the value of whichever digit is enabled.
    always_comb begin
        num = 4'h0;
        for (int i = 0; i < ND; i++) begin
            if (!en[i]) num = digit_val[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Cycle c counts clock edges since reset release; slots start at c = SD.
    task automatic model(input int c, output logic [7:0] en_e, output logic [6:0] seg_e,
                         output logic dp_e, output logic ft_e);
        int order[$];
        int k, sc, d;
        for (int i = 0; i < ND; i++) if (digit_mask[i]) order.push_back(i);
        en_e = 8'hFF; seg_e = 7'h7F; dp_e = 1'b1; ft_e = 1'b0;
        if (c >= SD && order.size() > 0) begin
            k  = (c - SD) / SD;
            sc = (c - SD) % SD;
            d  = order[k % order.size()];
            en_e[d] = 1'b0;
            ft_e    = (sc == 0) && (k % order.size() == 0);
            if (sc >= BL) begin
                seg_e = ~seg_table[prev_val[d]];
                dp_e  = ~dp_mask[d];
            end
        end
    endtask

    task automatic checkCycle(input int c);
        logic [7:0] en_e;
        logic [6:0] seg_e;
        logic       dp_e, ft_e;
        model(c, en_e, seg_e, dp_e, ft_e);
        checkOutput($sformatf("en m=%h c=%0d", digit_mask, c), en, en_e);
        checkOutput($sformatf("seg m=%h c=%0d", digit_mask, c), {1'b0, seg}, {1'b0, seg_e});
        checkOutput($sformatf("dp m=%h c=%0d", digit_mask, c), {7'b0, dp}, {7'b0, dp_e});
        checkOutput($sformatf("tick m=%h c=%0d", digit_mask, c), {7'b0, frame_tick}, {7'b0, ft_e});
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " en"}, en, 8'hFF);
        checkOutput({tag, " seg"}, {1'b0, seg}, 8'h7F);
        checkOutput({tag, " dp"}, {7'b0, dp}, 8'h01);
        checkOutput({tag, " tick"}, {7'b0, frame_tick}, 8'h00);
    endtask

    task automatic doReset(input logic [7:0] m, input logic [7:0] d);
        rst_n      = 1'b0;
        digit_mask = m;
        dp_mask    = d;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkIdle("in_reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc      = 0;
        prev_val = digit_val;
        checkCycle(0);
    endtask

    // Each cycle: check, then present new digit values (swept or random).
    task automatic applyStimulus(input int n, input bit sweep);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            checkCycle(cyc);
            for (int i = 0; i < ND; i++)
                digit_val[i] = sweep ? 4'(step % 16) : 4'($urandom_range(0, 15));
            step++;
            prev_val = digit_val;
        end
    endtask

    initial begin
        logic [7:0] rm;
        for (int i = 0; i < ND; i++) digit_val[i] = 4'(i);
        prev_val = digit_val;

        doReset(8'h03, 8'h02);
        applyStimulus(40, 1'b0);

        doReset(8'h10, 8'h10);
        applyStimulus(48, 1'b1);

        doReset(8'hA4, 8'h80);
        applyStimulus(40, 1'b0);

        doReset(8'h00, 8'hFF);
        applyStimulus(20, 1'b0);

        // Current digit's mask bit drops mid-slot, then returns before a boundary.
        doReset(8'h10, 8'h10);
        applyStimulus(6, 1'b0);
        digit_mask = 8'h00;
        @(posedge clk); #1;
        checkIdle("drop c7");
        @(posedge clk); #1;
        checkIdle("drop c8");
        digit_mask = 8'h10;
        for (int c = 9; c <= 11; c++) begin
            @(posedge clk); #1;
            checkIdle($sformatf("restore c%0d", c));
        end
        @(posedge clk); #1;
        checkOutput("restore c12 en", en, 8'hEF);
        checkOutput("restore c12 tick", {7'b0, frame_tick}, 8'h01);

        // Asynchronous reset while digit 1 is lit with its decimal point.
        doReset(8'h03, 8'h02);
        applyStimulus(10, 1'b0);
        rst_n = 1'b0;
        #1;
        checkIdle("async_rst");

        for (int t = 0; t < 6; t++) begin
            rm = 8'($urandom_range(0, 255));
            doReset(rm, 8'($urandom_range(0, 255)));
            applyStimulus(SD * ($countones(rm) + 2) + 3, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment display driver that sits directly downstream of the digit counter. It generates the rotating active-low digit enables (`en[0]`, `en[1]`, … feed the counter's `en0`/`en1` inputs). It takes back the 4-bit `num` the counter returns for the enabled digit, and drives registered, anti-ghosted segment and decimal-point lines to the board. It also emits a once-per-frame tick for refresh bookkeeping.

## Interface
- `NUM_DIGITS`, default 8: number of digit positions scanned (1..8).
- `SCAN_DIV`, default 100000: clk cycles per digit slot (1 ms at 100 MHz); must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, default 2: cycles at the start of each slot during which segments are forced off.
- `SEG_ACTIVE_LOW`, default 1: 1 = `seg`/`dp` are active-low; 0 = active-high.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `num`  in  4  hex value of the currently enabled digit (combinational from upstream, a function of `en`).
- `digit_mask`  in  NUM_DIGITS  1 = digit position in use; 0 = skipped by the scan.
- `dp_mask`  in  NUM_DIGITS  1 = light the decimal point on that digit.
- `en`  out  NUM_DIGITS  digit enables, active-low, at most one bit low.
- `seg`  out  7  segments a..g = `seg[0]`..`seg[6]`, registered.
- `dp`  out  1  decimal point, registered.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps back to a lower or equal digit index.

## Operation
- `div_cnt` counts 0..SCAN_DIV-1 and wraps. The cycle with `div_cnt`==SCAN_DIV-1 is the slot boundary.
- `idx` is the current digit and `act` is the slot-valid flag.
  - At each boundary, `idx` moves to the next set bit of `digit_mask` strictly above `idx`, searching circularly from bit 0 if none is found. `act` is set to 1.
  - If the current bit is the only one set, `idx` stays and the scan wraps.
  - If `digit_mask` is all zero, `act` is cleared.
- `en` is registered:
  - When `act`=1 and `digit_mask[idx]`=1, `en` = ~(1<<idx).
  - Otherwise `en` is all ones.
- Segment decode, active-high, hex digits 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71. The output is inverted when `SEG_ACTIVE_LOW`=1.
- `seg` and `dp` are registered every cycle:
  - Off while `div_cnt` < `BLANK_CYC` (counted in the new slot), or while `en` is all ones.
  - Otherwise `seg` = decode(`num`) and `dp` = `dp_mask[idx]`.
- `frame_tick` = 1 for the single cycle following a boundary at which the new `idx` ≤ the old `idx` and the new `act`=1.
- Mask changes:
  - `digit_mask` is sampled at boundaries for selection.
  - If the currently shown digit's bit drops mid-slot, `en` goes all ones and segments go off on the next cycle. The next boundary selects normally.
  - `dp_mask` takes effect immediately, subject to the one-cycle register delay.

## Timing
- Reset values: `div_cnt`=0, `idx`=NUM_DIGITS-1, `act`=0, `en`=all ones, `seg`/`dp`=off (all ones if `SEG_ACTIVE_LOW`), `frame_tick`=0.
- The first boundary occurs SCAN_DIV-1 cycles after reset release. Scan order then starts at the lowest set mask bit, and that first selection raises `frame_tick`.
- `en` changes on the cycle after the boundary; that edge is slot cycle 0.
- `seg`/`dp` are off for slot cycles 0..BLANK_CYC-1 (the register outputs lag by 1). Valid decode appears from slot cycle BLANK_CYC until the next slot's cycle 0.
- The `num` to `seg` latency is 1 cycle.
- Full frame length = popcount(`digit_mask`) × SCAN_DIV cycles.
- Asserting `rst_n` low mid-slot returns all outputs to their reset values immediately (asynchronous) and restarts the scan.

## Test plan
- Reset/power-up, with SCAN_DIV=4, BLANK_CYC=1, mask=8'h03: hold `rst_n`=0, then release.
  - During reset: `en`=FF, `seg`=7F, `dp`=1.
  - First boundary at cycle 3, then `en`=FE with `frame_tick`=1 for one cycle, then `en`=FD, then `en`=FE.
- Decode sweep: drive `num`=0..F while `en` is asserted past blanking; `seg`=~{3F,06,…,71} (e.g. `num`=4 → `seg`=7'h19).
- Blanking: on each slot change, `seg`=7F for exactly BLANK_CYC cycles, then the decode of `num`; no cycle shows the old digit's code with the new `en`.
- Sparse mask 8'b1010_0100: `en` sequence FB, DF, 7F, FB, …; `frame_tick` pulses only on the 7F→FB transition.
- Mask edge cases:
  - mask=0: `en`=FF and `seg` off permanently, `frame_tick`=0.
  - mask=8'h10: `en`=EF held, `frame_tick` every 4 cycles.
  - Clearing bit 4 mid-slot: `en`=FF on the next cycle.
- `dp`: `dp_mask`=8'h02 with mask=8'h03 → `dp`=0 only during digit 1's unblanked cycles; an async reset pulse mid-slot forces `dp`=1 and `en`=FF immediately.
